// File: rtl/led_breath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_breath_pkg
// Description : Shared constants, FSM state encoding and the gamma helper for
//               the four-channel breathing-LED PWM block.
// Revision    : 1.0 - initial release
// ============================================================================
package led_breath_pkg;

    // PWM counter / duty resolution
    localparam int PWM_BITS = 8;

    // Largest duty value; also the top of the brightness ramp
    localparam logic [PWM_BITS-1:0] DUTY_MAX = 8'd255;

    // Width of the step and hold counters (parameters go up to 65535)
    localparam int CNT_BITS = 16;

    // Brightness sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UP     = 3'd1,
        ST_HOLD_H = 3'd2,
        ST_DOWN   = 3'd3,
        ST_HOLD_L = 3'd4
    } state_e;

    // Perceptual brightness correction: square the duty and keep the top byte,
    // so full scale maps to 254 and small duties collapse towards zero.
    function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] d);
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
        return sq[2*PWM_BITS-1:PWM_BITS];
    endfunction

endpackage : led_breath_pkg
`default_nettype wire

// File: rtl/led_breath_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_channel
// Description : One PWM output. Derives its duty from the shared brightness
//               level (direct or inverted), optionally applies the gamma map,
//               compares against the shared PWM counter and registers the
//               result onto the LED pin.
//               Optional feature macro: GAMMA_EN (square-law duty mapping).
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_channel
    import led_breath_pkg::*;
#(
    parameter bit INVERT = 1'b0          // 1: duty = 255 - level (antiphase)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,      // synchronous clear (run enable low)
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic [PWM_BITS-1:0] i_level,
    output logic                o_led
);

    logic [PWM_BITS-1:0] w_lin_duty;
    logic [PWM_BITS-1:0] w_duty;
    logic                w_on;
    logic                r_led;

    // Linear duty: level itself, or its complement for the antiphase channels
    assign w_lin_duty = INVERT ? (DUTY_MAX - i_level) : i_level;

`ifdef GAMMA_EN
    assign w_duty = gamma_map(w_lin_duty);
`else
    assign w_duty = w_lin_duty;
`endif

    // Strict less-than: duty 0 never lights, duty 255 lights 255 of 256 cycles
    assign w_on = (i_pwm_cnt < w_duty);

    // Output register: one clock of latency from the compare to the pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= 1'b0;
        end else if (i_clr) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_on;
        end
    end

    assign o_led = r_led;

endmodule : led_pwm_channel
`default_nettype wire

// File: rtl/led_breath.sv
`default_nettype none
// ============================================================================
// Module      : led_breath
// Description : Four-channel "breathing" LED driver. An 8-bit PWM counter
//               defines the period; every STEP_PERIODS periods the brightness
//               level moves one step through UP -> HOLD_H -> DOWN -> HOLD_L.
//               Channels 0/2 follow the level, channels 1/3 its complement.
//               Optional feature macro: GAMMA_EN (square-law duty mapping,
//               implemented inside led_pwm_channel).
// Revision    : 1.0 - initial release
// ============================================================================
module led_breath
    import led_breath_pkg::*;
#(
    parameter int STEP_PERIODS = 4,      // PWM periods per brightness step, 1..65535
    parameter int HOLD_STEPS   = 64      // steps spent in each hold state, 1..65535
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [3:0] led
);

    localparam logic [CNT_BITS-1:0] c_step_last = CNT_BITS'(STEP_PERIODS - 1);
    localparam logic [CNT_BITS-1:0] c_hold_last = CNT_BITS'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] c_level_top = DUTY_MAX - 8'd1;

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [CNT_BITS-1:0] r_step_cnt;
    logic [CNT_BITS-1:0] r_hold_cnt;
    logic [PWM_BITS-1:0] r_level;
    state_e              r_state;

    logic                w_period_end;
    logic                w_step;
    logic                w_clr;

    // A period ends on the last count; a step is the period end that also
    // closes out the STEP_PERIODS group. Because the level only moves on that
    // edge, the new level is first seen with pwm_cnt == 0 (no partial period).
    assign w_period_end = (r_pwm_cnt == DUTY_MAX);
    assign w_step       = w_period_end && (r_step_cnt == c_step_last);
    assign w_clr        = ~en;

    // PWM period counter and period-end divider; both cleared while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt  <= '0;
            r_step_cnt <= '0;
        end else if (!en) begin
            r_pwm_cnt  <= '0;
            r_step_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_period_end) begin
                if (r_step_cnt == c_step_last) begin
                    r_step_cnt <= '0;
                end else begin
                    r_step_cnt <= r_step_cnt + 16'd1;
                end
            end
        end
    end

    // Brightness sequencer: saturating ramp up, hold, ramp down, hold, repeat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_level    <= '0;
            r_hold_cnt <= '0;
        end else if (!en) begin
            r_state    <= ST_IDLE;
            r_level    <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_UP;
                    r_level    <= '0;
                    r_hold_cnt <= '0;
                end
                ST_UP: begin
                    if (w_step) begin
                        // >= keeps the ramp saturating even from an odd level
                        if (r_level >= c_level_top) begin
                            r_level <= DUTY_MAX;
                            r_state <= ST_HOLD_H;
                        end else begin
                            r_level <= r_level + 8'd1;
                        end
                    end
                end
                ST_HOLD_H: begin
                    if (w_step) begin
                        if (r_hold_cnt == c_hold_last) begin
                            r_hold_cnt <= '0;
                            r_state    <= ST_DOWN;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 16'd1;
                        end
                    end
                end
                ST_DOWN: begin
                    if (w_step) begin
                        // <= keeps the ramp from ever wrapping below zero
                        if (r_level <= 8'd1) begin
                            r_level <= '0;
                            r_state <= ST_HOLD_L;
                        end else begin
                            r_level <= r_level - 8'd1;
                        end
                    end
                end
                ST_HOLD_L: begin
                    if (w_step) begin
                        if (r_hold_cnt == c_hold_last) begin
                            r_hold_cnt <= '0;
                            r_state    <= ST_UP;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_level    <= '0;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    // Four output channels; odd channels take the complemented level
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        led_pwm_channel #(
            .INVERT ((gi % 2) == 1)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_clr     (w_clr),
            .i_pwm_cnt (r_pwm_cnt),
            .i_level   (r_level),
            .o_led     (led[gi])
        );
    end

endmodule : led_breath
`default_nettype wire
